// File: rtl/gol_pkg.sv
// Shared Game of Life definitions: grid geometry, cell indexing and scan states.
// Used by both the datapath and the display-side scan driver.
package gol_pkg;

    localparam int GRID_ROWS  = 7;
    localparam int GRID_COLS  = 7;
    localparam int GRID_CELLS = GRID_ROWS * GRID_COLS;

    // SCAN drives the selected row; BLANK holds the matrix dark between rows.
    typedef enum logic {
        SCAN  = 1'b0,
        BLANK = 1'b1
    } scan_state_t;

    // Flat bit position of cell (r,c); row 0 occupies the low bits.
    function automatic int idx(input int r, input int c);
        return r * GRID_COLS + c;
    endfunction

endpackage

// File: rtl/gol_row_timer.sv
// Row-slot timer for the matrix scan: div_cnt paces each slot, row_idx
// walks rows 0..6. Everything advances on the falling edge of clka.
// With SCAN_DEADTIME_EN defined, in_dead flags the first DEAD clocks of a slot.
module gol_row_timer
    import gol_pkg::*;
#(
    parameter int DIV  = 1000,
    parameter int DEAD = 8
) (
    input  logic       clka,
    input  logic       rst,
    output logic [2:0] row_idx,
    output logic       row_wrap,
    output logic       frame_wrap,
    output logic       in_dead
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] div_cnt;

    assign row_wrap   = (div_cnt == CW'(DIV - 1));
    assign frame_wrap = row_wrap && (row_idx == 3'(GRID_ROWS - 1));

`ifdef SCAN_DEADTIME_EN
    assign in_dead = (div_cnt < CW'(DEAD));
`else
    // Dead time is compiled out; DEAD has no effect in this build.
    assign in_dead = 1'b0 && (DEAD > 0);
`endif

    // Slot counter wraps at DIV-1 and steps the row index, 6 wrapping to 0.
    always_ff @(negedge clka or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            row_idx <= '0;
        end else if (row_wrap) begin
            div_cnt <= '0;
            row_idx <= (row_idx == 3'(GRID_ROWS - 1)) ? 3'd0 : row_idx + 3'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gol_scan_driver.sv
// Display-side consumer of the 7x7 Game of Life grid. Accepts snapshots over
// valid/ready into a pending buffer and swaps them into the display buffer
// only at frame boundaries, so a displayed frame never mixes two generations.
// Optional feature macro: SCAN_DEADTIME_EN (blank the first DEAD clocks of
// every row slot for anti-ghosting).
module gol_scan_driver
    import gol_pkg::*;
#(
    parameter int DIV  = 1000,
    parameter int DEAD = 8
) (
    input  logic                  clka,
    input  logic                  rst,
    input  logic [GRID_CELLS-1:0] grid,
    input  logic                  grid_valid,
    output logic                  grid_ready,
    output logic [GRID_ROWS-1:0]  row_n,
    output logic [GRID_COLS-1:0]  col,
    output logic                  frame_done
);

    logic [GRID_CELLS-1:0] pending;
    logic [GRID_CELLS-1:0] display;
    logic                  pending_full;

    logic [2:0]            row_idx;
    logic                  row_wrap;
    logic                  frame_wrap;
    logic                  in_dead;
    logic                  blank;

    logic [GRID_ROWS-1:0]  row_n_d;
    logic [GRID_COLS-1:0]  col_d;

    gol_row_timer #(
        .DIV  (DIV),
        .DEAD (DEAD)
    ) u_row_timer (
        .clka       (clka),
        .rst        (rst),
        .row_idx    (row_idx),
        .row_wrap   (row_wrap),
        .frame_wrap (frame_wrap),
        .in_dead    (in_dead)
    );

    assign grid_ready = ~pending_full;
    assign frame_done = frame_wrap;

    // Pending/display double buffer: load on handshake, promote at frame end.
    always_ff @(negedge clka or posedge rst) begin
        if (rst) begin
            pending      <= '0;
            display      <= '0;
            pending_full <= 1'b0;
        end else if (frame_wrap && pending_full) begin
            display      <= pending;
            pending_full <= 1'b0;
        end else if (grid_valid && !pending_full) begin
            pending      <= grid;
            pending_full <= 1'b1;
        end
    end

`ifdef SCAN_DEADTIME_EN
    scan_state_t state;
    scan_state_t next_state;

    // State mirrors what the output registers show: BLANK while the slot's
    // dead window is being presented, SCAN while a row is driven.
    always_ff @(negedge clka or posedge rst) begin
        if (rst) begin
            state <= SCAN;
        end else begin
            state <= next_state;
        end
    end

    // Enter BLANK at the start of each slot, return to SCAN once DEAD clocks pass.
    always_comb begin
        next_state = state;
        case (state)
            SCAN:    if (in_dead)  next_state = BLANK;
            BLANK:   if (!in_dead) next_state = SCAN;
            default: next_state = SCAN;
        endcase
    end

    assign blank = (next_state == BLANK);
`else
    assign blank = in_dead;
`endif

    // Row select and column data for the current row, dark while blanking.
    always_comb begin
        row_n_d = '1;
        col_d   = '0;
        if (!blank) begin
            row_n_d = ~(7'b1 << row_idx);
            col_d   = display[idx(int'(row_idx), 0) +: GRID_COLS];
        end
    end

    // Matrix pins are registered, one clock behind the row timer.
    always_ff @(negedge clka or posedge rst) begin
        if (rst) begin
            row_n <= '1;
            col   <= '0;
        end else begin
            row_n <= row_n_d;
            col   <= col_d;
        end
    end

endmodule
